// File: rtl/txt_pkg.sv
// Shared constants and types for the text cursor controller.
// Build option: TXT_CTRL_LINE_CLR_EN adds the per-row clear state.
package txt_pkg;

  localparam int unsigned DefaultDataWidth = 9;
  localparam int unsigned DefaultRows      = 4;
  localparam int unsigned DefaultCols      = 32;

  localparam int unsigned CHAR_CR = 'h0D;
  localparam int unsigned CHAR_LF = 'h0A;
  localparam int unsigned CHAR_BS = 'h08;

`ifdef TXT_CTRL_LINE_CLR_EN
  typedef enum logic [1:0] {StIdle, StClear, StLineClr} state_e;
`else
  typedef enum logic [1:0] {StIdle, StClear} state_e;
`endif

endpackage

// File: rtl/addr_sweep.sv
// Row/column sweep counter used for full-grid and single-row clears.
// done_o pulses for one cycle after the final address has been presented.
module addr_sweep #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 32,
  localparam int unsigned RW = $clog2(ROWS),
  localparam int unsigned CW = $clog2(COLS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          row_mode_i,
  input  logic [RW-1:0] start_row_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          active_o,
  output logic          done_o
);

  localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);
  localparam logic [CW-1:0] ColLast = CW'(COLS - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          mode_q, mode_d;
  logic          last;

  // Explicit end-of-range compares keep non-power-of-two grids correct.
  always_comb begin
    row_d    = row_q;
    col_d    = col_q;
    active_d = active_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    last     = (col_q == ColLast) && (mode_q || (row_q == RowLast));
    if (start_i) begin
      row_d    = row_mode_i ? start_row_i : '0;
      col_d    = '0;
      mode_d   = row_mode_i;
      active_d = 1'b1;
    end else if (active_q) begin
      if (last) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end else if (col_q == ColLast) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Sweep state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q    <= '0;
      col_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      active_q <= active_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
    end
  end

  assign row_o    = row_q;
  assign col_o    = col_q;
  assign active_o = active_q;
  assign done_o   = done_q;

endmodule

// File: rtl/text_cursor_ctrl.sv
// Write-side controller for the character-grid RAM: cursor, CR/LF/BS handling
// and clear sweeps. Define TXT_CTRL_LINE_CLR_EN to blank each newly entered row.
module text_cursor_ctrl
  import txt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ROWS       = DefaultRows,
  parameter int unsigned COLS       = DefaultCols,
  localparam int unsigned RW = $clog2(ROWS),
  localparam int unsigned CW = $clog2(COLS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_lang,
  input  logic                  clear_req,
  output logic                  ram_we,
  output logic [RW-1:0]         ram_row,
  output logic [CW-1:0]         ram_col,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_lang,
  output logic [RW-1:0]         cur_row,
  output logic [CW-1:0]         cur_col,
  output logic                  busy
);

  localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);
  localparam logic [CW-1:0] ColLast = CW'(COLS - 1);

  state_e                  state_q, state_d;
  logic [RW-1:0]           cur_row_q, cur_row_d, row_next;
  logic [CW-1:0]           cur_col_q, cur_col_d;
  logic                    ram_we_q, ram_we_d;
  logic [RW-1:0]           ram_row_q, ram_row_d;
  logic [CW-1:0]           ram_col_q, ram_col_d;
  logic [DATA_WIDTH-1:0]   ram_din_q, ram_din_d;
  logic                    ram_lang_q, ram_lang_d;
  logic                    sw_start, sw_row_mode, sw_active, sw_done;
  logic [RW-1:0]           sw_start_row, sw_row;
  logic [CW-1:0]           sw_col;
  logic                    is_cr, is_lf, is_bs;

  assign is_cr    = (in_data == DATA_WIDTH'(CHAR_CR));
  assign is_lf    = (in_data == DATA_WIDTH'(CHAR_LF));
  assign is_bs    = (in_data == DATA_WIDTH'(CHAR_BS));
  assign row_next = (cur_row_q == RowLast) ? '0 : cur_row_q + 1'b1;
  assign in_ready = (state_q == StIdle) && !clear_req;

  addr_sweep #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_sweep (
    .clk_i      (clk),
    .rst_ni     (reset),
    .start_i    (sw_start),
    .row_mode_i (sw_row_mode),
    .start_row_i(sw_start_row),
    .row_o      (sw_row),
    .col_o      (sw_col),
    .active_o   (sw_active),
    .done_o     (sw_done)
  );

  // Next state, cursor and registered RAM write port.
  always_comb begin
    state_d      = state_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    ram_we_d     = 1'b0;
    ram_row_d    = ram_row_q;
    ram_col_d    = ram_col_q;
    ram_din_d    = ram_din_q;
    ram_lang_d   = ram_lang_q;
    sw_start     = 1'b0;
    sw_row_mode  = 1'b0;
    sw_start_row = '0;
    unique case (state_q)
      StIdle: begin
        // clear_req wins over a character offered in the same cycle.
        if (clear_req) begin
          state_d  = StClear;
          sw_start = 1'b1;
        end else if (in_valid) begin
          if (is_cr) begin
            cur_col_d = '0;
          end else if (is_lf) begin
            cur_row_d = row_next;
`ifdef TXT_CTRL_LINE_CLR_EN
            state_d      = StLineClr;
            sw_start     = 1'b1;
            sw_row_mode  = 1'b1;
            sw_start_row = row_next;
`endif
          end else if (is_bs) begin
            // Step back one cell and blank it; nothing happens at the origin.
            if (cur_col_q != '0) begin
              cur_col_d  = cur_col_q - 1'b1;
              ram_we_d   = 1'b1;
              ram_row_d  = cur_row_q;
              ram_col_d  = cur_col_q - 1'b1;
              ram_din_d  = '0;
              ram_lang_d = 1'b0;
            end else if (cur_row_q != '0) begin
              cur_row_d  = cur_row_q - 1'b1;
              cur_col_d  = ColLast;
              ram_we_d   = 1'b1;
              ram_row_d  = cur_row_q - 1'b1;
              ram_col_d  = ColLast;
              ram_din_d  = '0;
              ram_lang_d = 1'b0;
            end
          end else begin
            ram_we_d   = 1'b1;
            ram_row_d  = cur_row_q;
            ram_col_d  = cur_col_q;
            ram_din_d  = in_data;
            ram_lang_d = in_lang;
            if (cur_col_q == ColLast) begin
              cur_col_d = '0;
              cur_row_d = row_next;
`ifdef TXT_CTRL_LINE_CLR_EN
              state_d      = StLineClr;
              sw_start     = 1'b1;
              sw_row_mode  = 1'b1;
              sw_start_row = row_next;
`endif
            end else begin
              cur_col_d = cur_col_q + 1'b1;
            end
          end
        end
      end
      StClear: begin
        ram_we_d   = sw_active;
        ram_row_d  = sw_row;
        ram_col_d  = sw_col;
        ram_din_d  = '0;
        ram_lang_d = 1'b0;
        if (sw_done) begin
          state_d   = StIdle;
          cur_row_d = '0;
          cur_col_d = '0;
        end
      end
`ifdef TXT_CTRL_LINE_CLR_EN
      StLineClr: begin
        ram_we_d   = sw_active;
        ram_row_d  = sw_row;
        ram_col_d  = sw_col;
        ram_din_d  = '0;
        ram_lang_d = 1'b0;
        if (sw_done) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // FSM, cursor and RAM port registers; reset aborts any sweep at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_row_q  <= '0;
      ram_col_q  <= '0;
      ram_din_q  <= '0;
      ram_lang_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      ram_we_q   <= ram_we_d;
      ram_row_q  <= ram_row_d;
      ram_col_q  <= ram_col_d;
      ram_din_q  <= ram_din_d;
      ram_lang_q <= ram_lang_d;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_row  = ram_row_q;
  assign ram_col  = ram_col_q;
  assign ram_din  = ram_din_q;
  assign ram_lang = ram_lang_q;
  assign cur_row  = cur_row_q;
  assign cur_col  = cur_col_q;
  assign busy     = (state_q != StIdle);

endmodule
